// File: rtl/core_pkg.sv
// Shared RV32I decode constants, ALU/write-back encodings and the ID/EX control bundle.
package core_pkg;

  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'd0;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'd1;
  localparam logic [1:0] MEM_TO_REG_PC4 = 2'd2;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/control_unit.sv
// Main RV32I control decoder; opcodes outside the base set raise illegal with side effects off.
module control_unit
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output ctrl_t      ctrl
);

  alu_op_e arith_op;

  always_comb begin
    case (funct3)
      3'b000:  arith_op = (opcode == OPCODE_OP && funct7_b5) ? AluSub : AluAdd;
      3'b001:  arith_op = AluSll;
      3'b010:  arith_op = AluSlt;
      3'b011:  arith_op = AluSltu;
      3'b100:  arith_op = AluXor;
      3'b101:  arith_op = funct7_b5 ? AluSra : AluSrl;
      3'b110:  arith_op = AluOr;
      default: arith_op = AluAnd;
    endcase
  end

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = AluAdd;
    case (opcode)
      OPCODE_LUI, OPCODE_AUIPC: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPCODE_JAL, OPCODE_JALR: begin
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = MEM_TO_REG_PC4;
      end
      OPCODE_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = funct3[2] ? (funct3[1] ? AluSltu : AluSlt) : AluSub;
      end
      OPCODE_LOAD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = MEM_TO_REG_MEM;
      end
      OPCODE_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OPCODE_OP_IMM: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = arith_op;
      end
      OPCODE_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = arith_op;
      end
      OPCODE_MISC_MEM, OPCODE_SYSTEM: ;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_hazard_unit.sv
// Load-use hazard detection against the ID/EX slot and write-back bypass selects.
module id_hazard_unit
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       wb_we,
  input  logic [4:0] wb_rd,
  output logic       hazard,
  output logic       byp_rs1,
  output logic       byp_rs2
);

  logic use_rs1, use_rs2;

  always_comb begin
    use_rs1 = !(opcode inside {OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL});
    use_rs2 = opcode inside {OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
    hazard  = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
              ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    byp_rs1 = wb_we && (wb_rd != 5'd0) && (wb_rd == rs1);
    byp_rs2 = wb_we && (wb_rd != 5'd0) && (wb_rd == rs2);
  end

endmodule

// File: rtl/immediate_generator.sv
// Builds the sign-extended immediate for each RV32I instruction format.
module immediate_generator
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    case (instruction[6:0])
      OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR, OPCODE_MISC_MEM, OPCODE_SYSTEM:
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
      OPCODE_STORE:
        imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OPCODE_BRANCH:
        imm32 = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25],
                 instruction[11:8], 1'b0};
      OPCODE_LUI, OPCODE_AUIPC:
        imm32 = {instruction[31:12], 12'b0};
      OPCODE_JAL:
        imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20],
                 instruction[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage_pipe.sv
// Registered ID stage: decode, register read with WB bypass, load-use bubbles and flush.
// Define ID_TRACE_EN to print a trace line per accepted instruction and per bubble.
module id_stage_pipe
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      instruction_i,
  output logic [4:0]       rs1_addr_rf_o,
  output logic [4:0]       rs2_addr_rf_o,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic             wb_we_i,
  input  logic [4:0]       wb_rd_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic             ex_valid_o,
  input  logic             ex_ready_i,
  output logic [XLEN-1:0]  pc_ex_o,
  output logic [XLEN-1:0]  operand_a_ex_o,
  output logic [XLEN-1:0]  operand_b_ex_o,
  output logic [XLEN-1:0]  immediate_ex_o,
  output logic [4:0]       rs1_addr_ex_o,
  output logic [4:0]       rs2_addr_ex_o,
  output logic [4:0]       rd_addr_ex_o,
  output logic [2:0]       funct3_ex_o,
  output logic [6:0]       funct7_ex_o,
  output logic [6:0]       opcode_ex_o,
  output logic [3:0]       alu_op_ex_o,
  output logic             alu_src_ex_o,
  output logic             mem_read_ex_o,
  output logic             mem_write_ex_o,
  output logic             branch_ex_o,
  output logic             reg_write_ex_o,
  output logic [1:0]       mem_to_reg_ex_o,
  output logic             illegal_ex_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm, rs1_val, rs2_val, op_a;
  ctrl_t           ctrl_dec;
  logic            hazard, byp_rs1, byp_rs2, fire_in, fire_out;

  logic             ex_valid_q, ex_valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  pc_q, op_a_q, op_b_q, imm_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic [2:0]       funct3_q;
  logic [6:0]       funct7_q, opcode_q;

  assign opcode = instruction_i[6:0];
  assign rd     = instruction_i[11:7];
  assign rs1    = instruction_i[19:15];
  assign rs2    = instruction_i[24:20];

  control_unit u_control_unit (
    .opcode    (opcode),
    .funct3    (instruction_i[14:12]),
    .funct7_b5 (instruction_i[30]),
    .ctrl      (ctrl_dec)
  );

  immediate_generator #(.XLEN(XLEN)) u_immediate_generator (
    .instruction (instruction_i),
    .imm         (imm)
  );

  id_hazard_unit u_id_hazard_unit (
    .opcode      (opcode),
    .rs1         (rs1),
    .rs2         (rs2),
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .wb_we       (wb_we_i),
    .wb_rd       (wb_rd_i),
    .hazard      (hazard),
    .byp_rs1     (byp_rs1),
    .byp_rs2     (byp_rs2)
  );

  // Bypass beats the x0 check only because byp_* already excludes wb_rd == 0.
  always_comb begin
    rs1_val = byp_rs1 ? wb_data_i : ((rs1 == 5'd0) ? '0 : rs1_data_i);
    rs2_val = byp_rs2 ? wb_data_i : ((rs2 == 5'd0) ? '0 : rs2_data_i);
    if (opcode == OPCODE_LUI)        op_a = '0;
    else if (opcode == OPCODE_AUIPC) op_a = pc_i;
    else                             op_a = rs1_val;
  end

  assign in_ready_o = rst_n && !flush_i && !hazard && (!ex_valid_q || ex_ready_i);
  assign fire_in    = in_valid_i && in_ready_o;
  assign fire_out   = ex_valid_q && ex_ready_i;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
      ctrl_d     = '0;
    end else if (fire_in) begin
      ex_valid_d = 1'b1;
      ctrl_d     = ctrl_dec;
    end else if (fire_out) begin
      ex_valid_d = 1'b0;
      ctrl_d     = '0;
      if (hazard && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= '0;
      cnt_q      <= '0;
      pc_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      opcode_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
      if (fire_in) begin
        pc_q     <= pc_i;
        op_a_q   <= op_a;
        op_b_q   <= rs2_val;
        imm_q    <= imm;
        rs1_q    <= rs1;
        rs2_q    <= rs2;
        rd_q     <= rd;
        funct3_q <= instruction_i[14:12];
        funct7_q <= instruction_i[31:25];
        opcode_q <= opcode;
      end
    end
  end

`ifdef ID_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i) begin
      if (fire_in && opcode == OPCODE_LUI) begin
        $display("[ID] pc=%h instr=%h opcode=%b rd=x%0d value=%h", pc_i, instruction_i, opcode,
                 rd, imm);
      end else if (fire_in) begin
        $display("[ID] pc=%h instr=%h opcode=%b rd=x%0d", pc_i, instruction_i, opcode, rd);
      end else if (fire_out && hazard) begin
        $display("[ID] load-use bubble load_rd=x%0d rs1=x%0d rs2=x%0d", rd_q, rs1, rs2);
      end
    end
  end
`else
  // Trace disabled: nothing simulation-only is elaborated.
`endif

  assign ex_valid_o      = ex_valid_q;
  assign pc_ex_o         = pc_q;
  assign operand_a_ex_o  = op_a_q;
  assign operand_b_ex_o  = op_b_q;
  assign immediate_ex_o  = imm_q;
  assign rs1_addr_ex_o   = rs1_q;
  assign rs2_addr_ex_o   = rs2_q;
  assign rd_addr_ex_o    = rd_q;
  assign funct3_ex_o     = funct3_q;
  assign funct7_ex_o     = funct7_q;
  assign opcode_ex_o     = opcode_q;
  assign alu_op_ex_o     = ctrl_q.alu_op;
  assign alu_src_ex_o    = ctrl_q.alu_src;
  assign mem_read_ex_o   = ctrl_q.mem_read;
  assign mem_write_ex_o  = ctrl_q.mem_write;
  assign branch_ex_o     = ctrl_q.branch;
  assign reg_write_ex_o  = ctrl_q.reg_write;
  assign mem_to_reg_ex_o = ctrl_q.mem_to_reg;
  assign illegal_ex_o    = ctrl_q.illegal;
  assign bubble_cnt_o    = cnt_q;
  assign rs1_addr_rf_o   = rs1;
  assign rs2_addr_rf_o   = rs2;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed plus randomized bench for id_stage_pipe against a slot-level reference model.
module tb_id_stage_pipe;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0, flush_i = 1'b0, in_valid_i = 1'b0, ex_ready_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0] pc_i = '0, instruction_i = '0, rs1_data_i = '0, rs2_data_i = '0, wb_data_i = '0;
  logic [4:0]  wb_rd_i = '0;

  logic             in_ready_o, ex_valid_o;
  logic [4:0]       rs1_addr_rf_o, rs2_addr_rf_o, rs1_addr_ex_o, rs2_addr_ex_o, rd_addr_ex_o;
  logic [31:0]      pc_ex_o, operand_a_ex_o, operand_b_ex_o, immediate_ex_o;
  logic [2:0]       funct3_ex_o;
  logic [6:0]       funct7_ex_o, opcode_ex_o;
  logic [3:0]       alu_op_ex_o;
  logic             alu_src_ex_o, mem_read_ex_o, mem_write_ex_o, branch_ex_o, reg_write_ex_o;
  logic [1:0]       mem_to_reg_ex_o;
  logic             illegal_ex_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .pc_i(pc_i), .instruction_i(instruction_i),
    .rs1_addr_rf_o(rs1_addr_rf_o), .rs2_addr_rf_o(rs2_addr_rf_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i),
    .wb_data_i(wb_data_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .pc_ex_o(pc_ex_o), .operand_a_ex_o(operand_a_ex_o), .operand_b_ex_o(operand_b_ex_o),
    .immediate_ex_o(immediate_ex_o), .rs1_addr_ex_o(rs1_addr_ex_o),
    .rs2_addr_ex_o(rs2_addr_ex_o), .rd_addr_ex_o(rd_addr_ex_o), .funct3_ex_o(funct3_ex_o),
    .funct7_ex_o(funct7_ex_o), .opcode_ex_o(opcode_ex_o), .alu_op_ex_o(alu_op_ex_o),
    .alu_src_ex_o(alu_src_ex_o), .mem_read_ex_o(mem_read_ex_o),
    .mem_write_ex_o(mem_write_ex_o), .branch_ex_o(branch_ex_o),
    .reg_write_ex_o(reg_write_ex_o), .mem_to_reg_ex_o(mem_to_reg_ex_o),
    .illegal_ex_o(illegal_ex_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // Reference model: the contents of the ID/EX slot as the instruction set defines them.
  typedef struct packed {
    logic        v;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic        mr, mw, br, rw, ill;
  } slot_t;

  slot_t       m;
  int unsigned cnt;
  bit          killed, was_reset;
  int          tests = 0;
  int          fails = 0;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BR = 7'h63,
                         LD = 7'h03, ST = 7'h23, OPI = 7'h13, OP = 7'h33, FENCE = 7'h0F,
                         SYS = 7'h73;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [6:0] op);
    return op inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP, FENCE, SYS};
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] i);
    case (i[6:0])
      OPI, LD, JALR, FENCE, SYS: return 32'($signed(i[31:20]));
      ST:         return 32'($signed({i[31:25], i[11:7]}));
      BR:         return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      LUI, AUIPC: return i[31:12] * 32'd4096;
      JAL:        return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] src_val(input logic [4:0] r, input logic [31:0] rf);
    if (wb_we_i && wb_rd_i != 0 && wb_rd_i == r) return wb_data_i;
    return (r == 0) ? 32'd0 : rf;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 15))
      0, 1, 2: w[6:0] = LD;
      3:       w[6:0] = ST;
      4:       w[6:0] = BR;
      5, 6:    w[6:0] = OP;
      7:       w[6:0] = OPI;
      8:       w[6:0] = LUI;
      9:       w[6:0] = AUIPC;
      10:      w[6:0] = JAL;
      11:      w[6:0] = JALR;
      12:      w[6:0] = FENCE;
      13:      w[6:0] = SYS;
      default: w[6:0] = 7'($urandom);
    endcase
    return w;
  endfunction

  // Inputs are set just after a falling edge; step checks, clocks once and checks again.
  task automatic step();
    logic [6:0] op;
    logic [4:0] r1, r2;
    bit         u1, u2, hz, rdy;
    #1;
    op  = instruction_i[6:0];
    r1  = instruction_i[19:15];
    r2  = instruction_i[24:20];
    u1  = !(op inside {LUI, AUIPC, JAL});
    u2  = op inside {OP, ST, BR};
    hz  = m.v && m.mr && m.rd != 0 && ((u1 && r1 == m.rd) || (u2 && r2 == m.rd));
    rdy = rst_n && !flush_i && !hz && (!m.v || ex_ready_i);
    chk("in_ready", 32'(in_ready_o), 32'(rdy));
    chk("rs1_addr_rf", 32'(rs1_addr_rf_o), 32'(r1));
    chk("rs2_addr_rf", 32'(rs2_addr_rf_o), 32'(r2));
    @(posedge clk);
    killed    = 0;
    was_reset = 0;
    if (!rst_n) begin
      m = '0; cnt = 0; was_reset = 1;
    end else if (flush_i) begin
      m.v = 0; killed = 1;
    end else if (in_valid_i && rdy) begin
      m.v   = 1;
      m.pc  = pc_i;
      m.a   = (op == LUI) ? 32'd0 : (op == AUIPC) ? pc_i : src_val(r1, rs1_data_i);
      m.b   = src_val(r2, rs2_data_i);
      m.imm = imm_of(instruction_i);
      m.rs1 = r1; m.rs2 = r2; m.rd = instruction_i[11:7];
      m.f3  = instruction_i[14:12]; m.f7 = instruction_i[31:25]; m.op = op;
      m.ill = !legal(op);
      m.mr  = (op == LD);
      m.mw  = (op == ST);
      m.br  = (op == BR);
      m.rw  = legal(op) && !(op inside {ST, BR, FENCE, SYS});
    end else if (m.v && ex_ready_i) begin
      m.v = 0;
      if (hz) begin
        killed = 1;
        if (cnt < (1 << CNT_W) - 1) cnt++;
      end
    end
    #1;
    chk("ex_valid", 32'(ex_valid_o), 32'(m.v));
    chk("bubble_cnt", 32'(bubble_cnt_o), cnt);
    if (m.v || was_reset) begin
      chk("pc_ex", pc_ex_o, m.pc);
      chk("operand_a", operand_a_ex_o, m.a);
      chk("operand_b", operand_b_ex_o, m.b);
      chk("immediate", immediate_ex_o, m.imm);
      chk("rs1_ex", 32'(rs1_addr_ex_o), 32'(m.rs1));
      chk("rs2_ex", 32'(rs2_addr_ex_o), 32'(m.rs2));
      chk("rd_ex", 32'(rd_addr_ex_o), 32'(m.rd));
      chk("funct3", 32'(funct3_ex_o), 32'(m.f3));
      chk("funct7", 32'(funct7_ex_o), 32'(m.f7));
      chk("opcode", 32'(opcode_ex_o), 32'(m.op));
    end
    if (m.v || was_reset || killed) begin
      chk("mem_read", 32'(mem_read_ex_o), 32'(m.v & m.mr));
      chk("mem_write", 32'(mem_write_ex_o), 32'(m.v & m.mw));
      chk("branch", 32'(branch_ex_o), 32'(m.v & m.br));
      chk("reg_write", 32'(reg_write_ex_o), 32'(m.v & m.rw));
      chk("illegal", 32'(illegal_ex_o), 32'(m.v & m.ill));
    end
    if (was_reset) begin
      chk("alu_op_rst", 32'(alu_op_ex_o), 32'd0);
      chk("alu_src_rst", 32'(alu_src_ex_o), 32'd0);
      chk("mem_to_reg_rst", 32'(mem_to_reg_ex_o), 32'd0);
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] instr);
    in_valid_i    = 1'b1;
    instruction_i = instr;
    pc_i          = pc_i + 32'd4;
    step();
  endtask

  initial begin
    m = '0;
    cnt = 0;
    @(negedge clk);
    rst_n = 1'b0;
    step();
    step();

    rst_n = 1'b1; ex_ready_i = 1'b1; pc_i = 32'h0000_0100;
    issue(32'h0050_0093);                       // addi x1,x0,5
    chk("addi_rd", 32'(rd_addr_ex_o), 32'd1);
    chk("addi_imm", immediate_ex_o, 32'd5);
    chk("addi_opa", operand_a_ex_o, 32'd0);

    issue(32'h0000_A103);                       // lw x2,0(x1)
    issue(32'h0021_01B3);                       // add x3,x2,x2 -> bubble
    chk("lu_bubble_valid", 32'(ex_valid_o), 32'd0);
    chk("lu_bubble_cnt", 32'(bubble_cnt_o), 32'd1);
    step();                                      // add now accepted
    chk("lu_add_rd", 32'(rd_addr_ex_o), 32'd3);

    issue(32'h1234_52B7);                       // lui x5,0x12345
    ex_ready_i = 1'b0;
    instruction_i = 32'h0012_0313;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_in_ready", 32'(in_ready_o), 32'd0);
      chk("stall_imm", immediate_ex_o, 32'h1234_5000);
      chk("stall_opa", operand_a_ex_o, 32'd0);
    end

    ex_ready_i = 1'b1; flush_i = 1'b1;
    issue(32'h0010_0093);
    chk("flush_valid", 32'(ex_valid_o), 32'd0);
    chk("flush_cnt", 32'(bubble_cnt_o), 32'd1);
    flush_i = 1'b0;

    wb_we_i = 1'b1; wb_rd_i = 5'd4; wb_data_i = 32'hDEAD_BEEF; rs1_data_i = '0;
    issue(32'h0012_0313);                       // addi x6,x4,1
    chk("bypass_opa", operand_a_ex_o, 32'hDEAD_BEEF);
    wb_we_i = 1'b0;

    issue(32'h0000_007F);
    chk("illegal_flag", 32'(illegal_ex_o), 32'd1);
    chk("illegal_rw", 32'(reg_write_ex_o), 32'd0);
    chk("illegal_mw", 32'(mem_write_ex_o), 32'd0);

    for (int k = 0; k < 4; k++) begin
      issue(32'h0000_A103);
      issue(32'h0021_01B3);
    end
    chk("cnt_saturate", 32'(bubble_cnt_o), 32'd3);

    for (int n = 0; n < 2000; n++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      flush_i       = ($urandom_range(0, 15) == 0);
      in_valid_i    = ($urandom_range(0, 3) != 0);
      ex_ready_i    = ($urandom_range(0, 3) != 0);
      pc_i          = $urandom & 32'hFFFF_FFFC;
      instruction_i = rand_instr();
      rs1_data_i    = $urandom;
      rs2_data_i    = $urandom;
      wb_we_i       = 1'($urandom_range(0, 1));
      wb_rd_i       = 5'($urandom_range(0, 3));
      wb_data_i     = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered successor to the combinational ID stage of the RV32I core.
- Decodes the instruction and reads the register file. Results are captured into an ID/EX pipeline register.
- Uses a valid/ready handshake on both sides, plus internal load-use hazard bubbling, flush handling and write-back bypass.
- Sits between the IF/ID register and ex_stage, and reuses control_unit and immediate_generator.

Parameters:
- XLEN, 32, datapath width for PC, operands and immediates. Immediates are sign-extended to XLEN.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  kill instruction in ID and ID/EX (branch/jump redirect)
- in_valid_i  in  1  IF/ID holds a valid instruction
- in_ready_o  out  1  ID accepts the instruction this cycle
- pc_i  in  XLEN  PC of the instruction
- instruction_i  in  32  instruction word
- rs1_addr_rf_o  out  5  register-file read address 1 (combinational)
- rs2_addr_rf_o  out  5  register-file read address 2 (combinational)
- rs1_data_i  in  XLEN  register-file read data 1
- rs2_data_i  in  XLEN  register-file read data 2
- wb_we_i  in  1  write-back write enable
- wb_rd_i  in  5  write-back destination
- wb_data_i  in  XLEN  write-back data
- ex_valid_o  out  1  ID/EX holds a valid instruction
- ex_ready_i  in  1  EX accepts the ID/EX contents
- pc_ex_o  out  XLEN  registered PC
- operand_a_ex_o  out  XLEN  registered operand A
- operand_b_ex_o  out  XLEN  registered rs2 value
- immediate_ex_o  out  XLEN  registered immediate
- rs1_addr_ex_o, rs2_addr_ex_o, rd_addr_ex_o  out  5 each  registered addresses
- funct3_ex_o  out  3  registered funct3
- funct7_ex_o  out  7  registered funct7
- opcode_ex_o  out  7  registered opcode
- alu_op_ex_o  out  4  registered ALU op
- alu_src_ex_o, mem_read_ex_o, mem_write_ex_o, branch_ex_o, reg_write_ex_o  out  1 each  registered controls
- mem_to_reg_ex_o  out  2  registered write-back select
- illegal_ex_o  out  1  registered illegal-opcode flag
- bubble_cnt_o  out  CNT_W  saturating count of load-use bubbles

Behaviour:
Reset:
- rst_n=0 sampled on clk: all registered outputs 0, ex_valid_o=0, bubble_cnt_o=0.
- in_ready_o=0 while rst_n=0.

Handshake and timing:
- fire_in = in_valid_i & in_ready_o. fire_out = ex_valid_o & ex_ready_i.
- Latency: exactly 1 cycle from fire_in to the ID/EX register.
- Stall: while ex_valid_o=1 and ex_ready_i=0, every ID/EX output holds stable.

Load-use hazard:
- hazard = ex_valid_o & mem_read_ex_o & rd_addr_ex_o!=0 & ((use_rs1 & rs1==rd_addr_ex_o) | (use_rs2 & rs2==rd_addr_ex_o)).
- use_rs1 is 0 for LUI, AUIPC and JAL; 1 otherwise.
- use_rs2 is 1 for R-type, STORE and BRANCH only.
- in_ready_o = rst_n & !flush_i & !hazard & (!ex_valid_o | ex_ready_i).

Next state of ID/EX, in priority order:
- flush_i: ex_valid_o<=0. The instruction in ID is dropped. Flush wins over a simultaneous fire_in or hazard.
- fire_in: capture the decoded fields, ex_valid_o<=1.
- fire_out & hazard: insert a bubble. ex_valid_o<=0, and bubble_cnt_o increments, saturating at all ones.
- fire_out otherwise: ex_valid_o<=0.
- Otherwise: hold.
- A flush in the same cycle as a bubble still clears ex_valid_o but does not increment the counter.

Operand capture:
- x0 reads always yield 0.
- WB bypass: if wb_we_i & wb_rd_i!=0 & wb_rd_i==rs1, captured rs1 = wb_data_i; same for rs2. This is independent of register-file write-through.
- operand_a: LUI gives 0, AUIPC gives pc_i, otherwise bypassed rs1.
- operand_b_ex_o = bypassed rs2.

Illegal opcodes:
- An opcode outside the RV32I base set gives illegal_ex_o=1.
- For such an instruction, reg_write, mem_read, mem_write and branch are forced to 0. All other fields are captured normally.

Bubble fields:
- On a bubble or flush, the control bits are cleared to 0 along with ex_valid_o.
- Data fields are don't-care.

Optional Feature:
- Macro ID_TRACE_EN, defined: on each fire_in, print PC, instruction, opcode and rd. LUI instructions also print the value rd receives. On each bubble, print "[ID] load-use bubble" with both registers involved.
- Undefined: no simulation-only statements are elaborated. Function is identical.

Decomposition:
- Package core_pkg holds opcode constants (OPCODE_LUI, OPCODE_LOAD, ...), ALU op encodings, mem_to_reg encodings, and a typedef for the ID/EX control bundle.
- The natural sub-module is id_hazard_unit. It is combinational and derives use_rs1, use_rs2, the hazard term and the bypass selects.
- control_unit and immediate_generator are instantiated unchanged.

Test Plan:
- Reset, then `addi x1,x0,5` (0x00500093) with in_valid_i=1 and ex_ready_i=1 -> next cycle ex_valid_o=1, rd_addr_ex_o=1, immediate_ex_o=5, operand_a_ex_o=0.
- `lw x2,0(x1)` followed by `add x3,x2,x2` -> in_ready_o=0 for one cycle and a one-cycle ex_valid_o=0 bubble; bubble_cnt_o=1; the add reaches EX one cycle later.
- ex_ready_i=0 for 3 cycles with `lui x5,0x12345` in ID/EX -> outputs stable, operand_a_ex_o=0, immediate_ex_o=0x12345000, in_ready_o=0.
- flush_i=1 together with in_valid_i=1 -> next cycle ex_valid_o=0, instruction dropped, bubble_cnt_o unchanged.
- wb_we_i=1, wb_rd_i=4, wb_data_i=0xDEADBEEF, rs1_data_i=0 for `addi x6,x4,1` -> operand_a_ex_o=0xDEADBEEF.
- Instruction 0x0000007F -> illegal_ex_o=1, reg_write_ex_o=0, mem_write_ex_o=0. With CNT_W=2, four load-use bubbles -> bubble_cnt_o saturates at 3.
